line_fetch_arbiter: RTL and testbench

- Shares the single external memory port (SDRAM/SRAM controller) between two requesters:
  - per-line framebuffer prefetch into a double-banked line buffer, paced by video_timing's newline/newframe/visible_line;
  - host (CPU/UART bridge) read/write accesses.
- Video has priority. Host is guaranteed one slot per HOST_SLOT_EVERY video words, so it is never starved.

---
 rtl/line_fetch_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_line_fetch_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetch_arbiter.sv
// Shares one memory port between per-line framebuffer prefetch (priority) and host accesses.
// Latency: grant 1 cycle after the IDLE decision; lb_we / host_ack 1 cycle after mem_ack.
// Backpressure: mem_req is held until mem_ack; host_req is held until host_ack; one access in flight.
module line_fetch_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_LINE  = 128,
  parameter int LINE_STRIDE     = 128,
  parameter int FB_BASE         = 0,
  parameter int HOST_SLOT_EVERY = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              newline,
  input  logic                              newframe,
  input  logic                              visible_line,
  input  logic                              host_req,
  input  logic                              host_we,
  input  logic [ADDR_W-1:0]                 host_addr,
  input  logic [DATA_W-1:0]                 host_wdata,
  output logic                              host_ack,
  output logic [DATA_W-1:0]                 host_rdata,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic                              mem_ack,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic                              lb_we,
  output logic [$clog2(WORDS_PER_LINE):0]   lb_addr,
  output logic [DATA_W-1:0]                 lb_wdata,
  output logic                              lb_display_bank,
  output logic                              fetch_overrun
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int VSH_W = $clog2(HOST_SLOT_EVERY + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VID  = 2'd1;
  localparam logic [1:0] HOST = 2'd2;

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(LINE_STRIDE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [VSH_W-1:0]  SLOT_MAX = VSH_W'(HOST_SLOT_EVERY);

  logic [1:0]        state;
  logic [ADDR_W-1:0] line_cnt;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  word_idx;
  logic              fetch_pending;
  logic              fill_bank;
  logic              vid_discard;
  logic [VSH_W-1:0]  vid_since_host;

  logic              start_line;
  logic              vid_win;
  logic              host_win;
  logic              vid_done;
  logic              host_done;
  logic [ADDR_W-1:0] eff_cnt;
  logic [ADDR_W-1:0] line_base;

  assign start_line = newline && visible_line;

  // newframe zeroes the counter before a coincident visible line uses it,
  // so the first line of a frame fetches from FB_BASE and leaves line_cnt=1.
  assign eff_cnt   = newframe ? '0 : line_cnt;
  assign line_base = BASE_A + eff_cnt * STRIDE_A;

  // No video grant on the cycle a new line restarts the fetch: the granted
  // address would belong to the line being abandoned.
  assign vid_win  = (state == IDLE) && fetch_pending && !start_line &&
                    (!host_req || (vid_since_host < SLOT_MAX));
  // host_req is ignored during the host_ack cycle so a completed request is
  // not granted a second time before the host has seen its ack.
  assign host_win = (state == IDLE) && !vid_win && host_req && !host_ack;

  assign vid_done  = (state == VID)  && mem_ack;
  assign host_done = (state == HOST) && mem_ack;

  // Line tracking: counter, fetch base, bank swap, word progress, overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt        <= '0;
      base            <= '0;
      word_idx        <= '0;
      fetch_pending   <= 1'b0;
      fill_bank       <= 1'b0;
      lb_display_bank <= 1'b0;
      fetch_overrun   <= 1'b0;
    end else begin
      fetch_overrun <= start_line && fetch_pending;
      if (start_line) begin
        line_cnt        <= eff_cnt + ADDR_W'(1);
        base            <= line_base;
        word_idx        <= '0;
        fetch_pending   <= 1'b1;
        fill_bank       <= ~fill_bank;
        lb_display_bank <= fill_bank;
      end else begin
        line_cnt <= eff_cnt;
        if (vid_done && !vid_discard) begin
          word_idx <= word_idx + IDX_W'(1);
          if (word_idx == LAST_IDX) begin
            fetch_pending <= 1'b0;
          end
        end
      end
    end
  end

  // Arbitration FSM and registered memory port; one transaction at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      vid_discard    <= 1'b0;
      vid_since_host <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (vid_win) begin
            state       <= VID;
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= base + ADDR_W'(word_idx);
            mem_wdata   <= '0;
            vid_discard <= 1'b0;
          end else if (host_win) begin
            state     <= HOST;
            mem_req   <= 1'b1;
            mem_we    <= host_we;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
          end
        end
        VID: begin
          // A line restart orphans the in-flight word; let it finish, drop its data.
          if (start_line) begin
            vid_discard <= 1'b1;
          end
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (vid_since_host < SLOT_MAX) begin
              vid_since_host <= vid_since_host + VSH_W'(1);
            end
          end
        end
        HOST: begin
          if (mem_ack) begin
            state          <= IDLE;
            mem_req        <= 1'b0;
            vid_since_host <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion strobes toward the line buffer and the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_we      <= 1'b0;
      lb_addr    <= '0;
      lb_wdata   <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      lb_we    <= vid_done && !vid_discard && !start_line;
      host_ack <= host_done;
      if (vid_done) begin
        lb_addr  <= {fill_bank, word_idx};
        lb_wdata <= mem_rdata;
      end
      if (host_done) begin
        host_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Scoreboard bench for line_fetch_arbiter with a variable-latency memory model.
// Latency: expected line-buffer writes / host results are queued at stimulus time.
// Backpressure: host requests are held until host_ack; memory acks once per request.
module tb_line_fetch_arbiter;

  logic        clk;
  logic        rst_n;
  logic        newline, newframe, visible_line;
  logic        host_req, host_we;
  logic [15:0] host_addr, host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        lb_we;
  logic [7:0]  lb_addr;
  logic [15:0] lb_wdata;
  logic        lb_display_bank;
  logic        fetch_overrun;

  line_fetch_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .newline(newline), .newframe(newframe), .visible_line(visible_line),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .lb_display_bank(lb_display_bank), .fetch_overrun(fetch_overrun)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 2;
  int last_ack_cyc = 0;
  int wr_cnt = 0;
  int overrun_cnt = 0;
  int req_rises = 0;
  int vid_grants = 0;
  bit seen_host = 0;
  bit count_slots = 0;
  logic req_prev = 1'b0;
  logic [15:0] last_waddr, last_wdata;
  logic [15:0] mem_arr [0:65535];
  logic [23:0] lb_exp [$];
  logic [16:0] host_exp [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: acks once per request after mem_lat sampled cycles.
  initial begin : mem_model
    int cnt;
    bit served;
    cnt = 0;
    served = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!rst_n) begin
        cnt = 0;
        served = 0;
      end else if (!mem_req) begin
        served = 0;
      end else if (!served) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          served = 1;
          mem_ack = 1'b1;
          last_ack_cyc = cyc;
          if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
            wr_cnt++;
          end else begin
            mem_rdata = mem_arr[mem_addr];
          end
        end
      end
    end
  end

  // Output monitor: pops scoreboard entries, counts grants and overruns.
  initial forever begin
    logic [23:0] e;
    logic [16:0] h;
    @(negedge clk);
    if (rst_n) begin
      if (fetch_overrun) overrun_cnt++;
      if (lb_we) begin
        if (lb_exp.size() == 0) begin
          check("lb_unexpected", 32'(lb_we), 32'd0);
        end else begin
          e = lb_exp.pop_front();
          check("lb_addr", 32'(lb_addr), 32'(e[23:16]));
          check("lb_data", 32'(lb_wdata), 32'(e[15:0]));
        end
      end
      if (host_ack) begin
        check("host_ack_lat", cyc, last_ack_cyc + 1);
        if (host_exp.size() == 0) begin
          check("host_unexpected", 32'(host_ack), 32'd0);
        end else begin
          h = host_exp.pop_front();
          if (h[16]) check("host_rdata", 32'(host_rdata), 32'(h[15:0]));
        end
      end
      if (mem_req && !req_prev) begin
        req_rises++;
        if (count_slots) begin
          if (mem_addr >= 16'h8000) begin
            if (seen_host) check("vid_slots", vid_grants, 8);
            seen_host = 1;
            vid_grants = 0;
          end else begin
            vid_grants++;
          end
        end
      end
    end
    req_prev = mem_req;
  end

  task automatic pulse_line(input bit nf, input bit vis, input logic [15:0] base, input bit bank);
    if (vis) begin
      for (int i = 0; i < 128; i++) lb_exp.push_back({bank, 7'(i), pat(base + 16'(i))});
    end
    @(negedge clk);
    newline = 1'b1; newframe = nf; visible_line = vis;
    @(negedge clk);
    newline = 1'b0; newframe = 1'b0; visible_line = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    for (int n = 0; n < budget && lb_exp.size() != 0; n++) @(negedge clk);
    check(tag, lb_exp.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic host_xfer(input logic we, input logic [15:0] a, input logic [15:0] d,
                           input bit keep, input logic [15:0] exp_rd);
    bit got;
    got = 0;
    host_exp.push_back({~we, exp_rd});
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    for (int n = 0; n < 5000 && !got; n++) begin
      @(negedge clk);
      if (host_ack) got = 1;
    end
    if (!got) check("host_timeout", 32'(got), 32'd1);
    if (!keep) host_req = 1'b0;
  endtask

  initial begin
    int snap;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    for (int a = 0; a < 65536; a++) mem_arr[a] = pat(16'(a));
    rst_n = 1'b0;
    newline = 0; newframe = 0; visible_line = 0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_host_ack", 32'(host_ack), 0);
    check("rst_lb_we", 32'(lb_we), 0);
    check("rst_lb_addr", 32'(lb_addr), 0);
    check("rst_disp_bank", 32'(lb_display_bank), 0);
    check("rst_overrun", 32'(fetch_overrun), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First line of a frame: addr 0..127 into bank 1.
    mem_lat = 2;
    pulse_line(1, 1, 16'd0, 1'b1);
    check("l0_disp_bank", 32'(lb_display_bank), 0);
    wait_empty("l0_done", 2000);

    // Second line: addr 128..255 into bank 0.
    pulse_line(0, 1, 16'd128, 1'b0);
    check("l1_disp_bank", 32'(lb_display_bank), 1);
    wait_empty("l1_done", 2000);

    // New frame restarts at address 0.
    pulse_line(1, 1, 16'd0, 1'b1);
    check("nf_disp_bank", 32'(lb_display_bank), 0);
    wait_empty("nf_done", 2000);

    // Host write while idle, then read it back.
    host_xfer(1'b1, 16'h1234, 16'hBEEF, 0, 16'h0000);
    check("hw_count", wr_cnt, 1);
    check("hw_addr", 32'(last_waddr), 32'h1234);
    check("hw_data", 32'(last_wdata), 32'hBEEF);
    repeat (3) @(negedge clk);
    host_xfer(1'b0, 16'h1234, 16'h0000, 0, 16'hBEEF);
    repeat (3) @(negedge clk);

    // Host reads held continuously during a fetch: 8 video grants per host slot.
    count_slots = 1;
    pulse_line(0, 1, 16'd128, 1'b0);
    for (int k = 0; k < 10; k++) host_xfer(1'b0, 16'h8000 + 16'(k), 16'h0000, k != 9, pat(16'h8000 + 16'(k)));
    count_slots = 0;
    wait_empty("mix_done", 3000);
    check("mix_host_left", host_exp.size(), 0);
    check("no_overrun_yet", overrun_cnt, 0);

    // Slow memory: second newline arrives mid-fetch.
    mem_lat = 20;
    pulse_line(0, 1, 16'd256, 1'b1);
    for (int n = 0; n < 2000 && lb_exp.size() > 124; n++) @(negedge clk);
    for (int n = 0; n < 200 && !mem_req; n++) @(negedge clk);
    check("ovr_inflight", 32'(mem_req), 1);
    repeat (3) @(negedge clk);
    lb_exp.delete();
    pulse_line(0, 1, 16'd384, 1'b0);
    repeat (2) @(negedge clk);
    check("ovr_pulse", overrun_cnt, 1);
    check("ovr_disp_bank", 32'(lb_display_bank), 1);
    wait_empty("ovr_done", 6000);
    check("ovr_once", overrun_cnt, 1);

    // Reset asserted mid-fetch.
    mem_lat = 2;
    pulse_line(0, 1, 16'd512, 1'b1);
    for (int n = 0; n < 2000 && lb_exp.size() > 120; n++) @(negedge clk);
    for (int n = 0; n < 50 && !mem_req; n++) @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 0);
    check("arst_lb_we", 32'(lb_we), 0);
    check("arst_host_ack", 32'(host_ack), 0);
    lb_exp.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap = req_rises;
    repeat (20) @(negedge clk);
    pulse_line(0, 0, 16'd0, 1'b0);
    repeat (20) @(negedge clk);
    check("post_rst_idle", req_rises - snap, 0);
    check("post_rst_disp", 32'(lb_display_bank), 0);

    // First visible line after reset starts from line 0 into bank 1.
    pulse_line(0, 1, 16'd0, 1'b1);
    wait_empty("post_rst_line", 2000);
    check("final_overruns", overrun_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
